// File: rtl/control_sequencer.sv
// control_sequencer: fetch/decode/execute FSM for the 4-bit microcontroller.
// It drives the one-hot control bus that the datapath registers, the PC and the ALU load from.
// Each instruction takes three cycles: FETCH (latch IR), INC (bump PC) and EXEC (decoded op).
//
// Ports:
//   clk          system clock, rising edge
//   reset_n      asynchronous active-low reset
//   start        level; leaves IDLE/HALT when high
//   single_step  1 = return to IDLE after each instruction
//   instr        program memory word addressed by the external PC
//   zero_flag    ALU zero flag (registered externally)
//   carry_flag   ALU carry flag (registered externally)
//   control      registered one-hot control word (all-zero = no-op)
//   imm          IR immediate field
//   busy         high in FETCH/INC/EXEC
//   halted       high in HALT
module control_sequencer #(
  parameter int unsigned INSTR_W  = 8,
  parameter int unsigned DATA_W   = 4,
  parameter bit          AUTO_RUN = 1'b0
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic               single_step,
  input  logic [INSTR_W-1:0] instr,
  input  logic               zero_flag,
  input  logic               carry_flag,
  output logic [15:0]        control,
  output logic [DATA_W-1:0]  imm,
  output logic               busy,
  output logic               halted
);

  // Control bus bit positions
  localparam int unsigned CtlIrLd   = 0;
  localparam int unsigned CtlPcInc  = 1;
  localparam int unsigned CtlPcLd   = 2;
  localparam int unsigned CtlALd    = 3;
  localparam int unsigned CtlBLd    = 4;
  localparam int unsigned CtlAdd    = 5;
  localparam int unsigned CtlSub    = 6;
  localparam int unsigned CtlAnd    = 7;
  localparam int unsigned CtlOr     = 8;
  localparam int unsigned CtlXor    = 9;
  localparam int unsigned CtlOutLd  = 10;
  localparam int unsigned CtlFlgClr = 11;
  localparam int unsigned CtlHalt   = 15;

  localparam logic [3:0] OpHlt = 4'hF;

  typedef enum logic [2:0] {StIdle, StFetch, StInc, StExec, StHalt} state_e;

  state_e             state_q, state_d;
  logic [15:0]        control_q, control_d;
  logic [INSTR_W-1:0] ir_q;
  logic               auto_q, auto_d;
  logic [3:0]         opcode;
  logic [15:0]        exec_ctl;

  assign opcode = ir_q[INSTR_W-1 -: 4];

  // EXEC control word. Decoded while in INC, so the flags seen here are the
  // values at the end of INC.
  always_comb begin
    exec_ctl = '0;
    case (opcode)
      4'h1:    exec_ctl[CtlALd]    = 1'b1;
      4'h2:    exec_ctl[CtlBLd]    = 1'b1;
      4'h3:    exec_ctl[CtlAdd]    = 1'b1;
      4'h4:    exec_ctl[CtlSub]    = 1'b1;
      4'h5:    exec_ctl[CtlAnd]    = 1'b1;
      4'h6:    exec_ctl[CtlOr]     = 1'b1;
      4'h7:    exec_ctl[CtlXor]    = 1'b1;
      4'h8:    exec_ctl[CtlOutLd]  = 1'b1;
      4'h9:    exec_ctl[CtlPcLd]   = 1'b1;
      4'hA:    exec_ctl[CtlPcLd]   = zero_flag;
      4'hB:    exec_ctl[CtlPcLd]   = carry_flag;
      4'hC:    exec_ctl[CtlFlgClr] = 1'b1;
      default: exec_ctl            = '0; // NOP, reserved D/E, HLT
    endcase
  end

  always_comb begin
    state_d   = state_q;
    auto_d    = auto_q;
    control_d = '0;

    case (state_q)
      StIdle: begin
        // auto_q only survives until the first exit from IDLE after reset
        if (start || auto_q) begin
          state_d = StFetch;
          auto_d  = 1'b0;
        end
      end
      StFetch: state_d = StInc;
      StInc:   state_d = StExec;
      StExec: begin
        if (opcode == OpHlt) begin
          state_d = StHalt;
        end else if (single_step) begin
          state_d = StIdle;
        end else begin
          state_d = StFetch;
        end
      end
      StHalt: begin
        if (start) begin
          state_d = StFetch;
        end
      end
      default: state_d = StIdle;
    endcase

    // control is registered against the state being entered
    case (state_d)
      StFetch: control_d[CtlIrLd]  = 1'b1;
      StInc:   control_d[CtlPcInc] = 1'b1;
      StExec:  control_d           = exec_ctl;
      StHalt:  control_d[CtlHalt]  = 1'b1;
      default: control_d           = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= StIdle;
      control_q <= '0;
      ir_q      <= '0;
      auto_q    <= AUTO_RUN;
    end else begin
      state_q   <= state_d;
      control_q <= control_d;
      auto_q    <= auto_d;
      if (state_q == StFetch) begin
        ir_q <= instr;
      end
    end
  end

  assign control = control_q;
  assign imm     = ir_q[DATA_W-1:0];
  assign busy    = (state_q == StFetch) || (state_q == StInc) || (state_q == StExec);
  assign halted  = (state_q == StHalt);

endmodule

// File: tb/tb_control_sequencer.sv
// Self-checking bench for control_sequencer: directed steps followed by a randomized
// instruction stream checked against an opcode-table model, then reset and AUTO_RUN checks.
module tb_control_sequencer;

  logic        clk;
  logic        reset_n;
  logic        reset_auto_n;
  logic        start;
  logic        single_step;
  logic [7:0]  instr;
  logic        zero_flag;
  logic        carry_flag;
  logic [15:0] control;
  logic [3:0]  imm;
  logic        busy;
  logic        halted;
  logic [15:0] control_a;
  logic [3:0]  imm_a;
  logic        busy_a;
  logic        halted_a;

  int n_cmp = 0;
  int n_bad = 0;

  control_sequencer #(
    .INSTR_W  (8),
    .DATA_W   (4),
    .AUTO_RUN (1'b0)
  ) u_dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .start       (start),
    .single_step (single_step),
    .instr       (instr),
    .zero_flag   (zero_flag),
    .carry_flag  (carry_flag),
    .control     (control),
    .imm         (imm),
    .busy        (busy),
    .halted      (halted)
  );

  control_sequencer #(
    .INSTR_W  (8),
    .DATA_W   (4),
    .AUTO_RUN (1'b1)
  ) u_dut_auto (
    .clk         (clk),
    .reset_n     (reset_auto_n),
    .start       (start),
    .single_step (single_step),
    .instr       (instr),
    .zero_flag   (zero_flag),
    .carry_flag  (carry_flag),
    .control     (control_a),
    .imm         (imm_a),
    .busy        (busy_a),
    .halted      (halted_a)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Advance one clock and sample 1 time unit after the edge; invariants every cycle.
  task automatic tick();
    @(posedge clk);
    #1;
    chk1("onehot0", $onehot0(control), 1'b1);
    chk1("busy_halted_excl", busy & halted, 1'b0);
    chk1("onehot0_auto", $onehot0(control_a), 1'b1);
  endtask

  // Reference: control word expected in EXEC, from the opcode table.
  function automatic logic [15:0] model_exec(input logic [7:0] ins, input bit zf, input bit cf);
    int          pos;
    logic [15:0] one;
    one = 16'h0001;
    case (ins[7:4])
      4'h1:                         pos = 3;
      4'h2:                         pos = 4;
      4'h3, 4'h4, 4'h5, 4'h6, 4'h7: pos = int'(ins[7:4]) + 2;
      4'h8:                         pos = 10;
      4'h9:                         pos = 2;
      4'hA:                         pos = zf ? 2 : -1;
      4'hB:                         pos = cf ? 2 : -1;
      4'hC:                         pos = 11;
      default:                      pos = -1;
    endcase
    return (pos < 0) ? 16'h0000 : (one << pos);
  endfunction

  // Entered during a FETCH cycle; leaves in the cycle after EXEC.
  // Flags are scrambled outside INC to show only their end-of-INC value matters.
  task automatic do_instr(input logic [7:0] ins, input bit zf, input bit cf, input bit ss,
                          input logic [15:0] exp_exec);
    chk16("fetch_ctl", control, 16'h0001);
    chk1("fetch_busy", busy, 1'b1);
    chk1("fetch_halted", halted, 1'b0);
    instr       = ins;
    zero_flag   = 1'($urandom);
    carry_flag  = 1'($urandom);
    single_step = 1'($urandom);
    tick();
    chk16("inc_ctl", control, 16'h0002);
    chk16("inc_imm", {12'h000, imm}, {12'h000, ins[3:0]});
    chk1("inc_busy", busy, 1'b1);
    instr       = 8'($urandom);
    zero_flag   = zf;
    carry_flag  = cf;
    single_step = ss;
    tick();
    chk16("exec_ctl", control, exp_exec);
    chk1("exec_busy", busy, 1'b1);
    zero_flag  = 1'($urandom);
    carry_flag = 1'($urandom);
    tick();
  endtask

  initial begin
    logic [7:0]  r_ins;
    bit          r_zf, r_cf, r_ss;
    int unsigned gap;

    reset_n      = 1'b0;
    reset_auto_n = 1'b0;
    start        = 1'b0;
    single_step  = 1'b0;
    instr        = 8'h00;
    zero_flag    = 1'b0;
    carry_flag   = 1'b0;

    tick();
    tick();
    chk16("rst_ctl", control, 16'h0000);
    chk16("rst_imm", {12'h000, imm}, 16'h0000);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_halted", halted, 1'b0);

    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk16("idle_wait_ctl", control, 16'h0000);
      chk1("idle_wait_busy", busy, 1'b0);
    end

    // LDA 5 then free-run through LDA/LDB/ADD with no idle cycle between
    start = 1'b1;
    tick();
    start = 1'b0;
    do_instr(8'h15, 1'b0, 1'b0, 1'b0, 16'h0008);
    do_instr(8'h13, 1'b0, 1'b0, 1'b0, 16'h0008);
    do_instr(8'h22, 1'b0, 1'b0, 1'b0, 16'h0010);
    do_instr(8'h30, 1'b0, 1'b0, 1'b0, 16'h0020);

    // JZ taken / not taken
    do_instr(8'hA7, 1'b1, 1'b0, 1'b0, 16'h0004);
    chk16("jz_imm", {12'h000, imm}, 16'h0007);
    do_instr(8'hA7, 1'b0, 1'b1, 1'b0, 16'h0000);

    // HLT holds HALT_IND until start
    do_instr(8'hF0, 1'b0, 1'b0, 1'b0, 16'h0000);
    for (int i = 0; i < 12; i++) begin
      chk16("halt_ctl", control, 16'h8000);
      chk1("halt_halted", halted, 1'b1);
      chk1("halt_busy", busy, 1'b0);
      tick();
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    chk1("resume_halted", halted, 1'b0);

    // Single step OUT, then IDLE with nothing happening
    do_instr(8'h80, 1'b0, 1'b0, 1'b1, 16'h0400);
    for (int i = 0; i < 5; i++) begin
      chk16("step_idle_ctl", control, 16'h0000);
      chk1("step_idle_busy", busy, 1'b0);
      tick();
    end

    // Randomized instruction stream; start with single_step also high must still run
    start       = 1'b1;
    single_step = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 80; k++) begin
      r_ins = 8'($urandom);
      r_zf  = 1'($urandom);
      r_cf  = 1'($urandom);
      r_ss  = ($urandom_range(0, 3) == 0);
      do_instr(r_ins, r_zf, r_cf, r_ss, model_exec(r_ins, r_zf, r_cf));
      if (r_ins[7:4] == 4'hF || r_ss) begin
        gap = $urandom_range(1, 4);
        for (int g = 0; g < int'(gap); g++) begin
          if (r_ins[7:4] == 4'hF) begin
            chk16("rnd_halt_ctl", control, 16'h8000);
            chk1("rnd_halt_halted", halted, 1'b1);
          end else begin
            chk16("rnd_idle_ctl", control, 16'h0000);
            chk1("rnd_idle_halted", halted, 1'b0);
          end
          chk1("rnd_wait_busy", busy, 1'b0);
          tick();
        end
        start       = 1'b1;
        single_step = 1'($urandom);
        tick();
        start = 1'b0;
      end
    end

    // Reset asserted mid-INC clears control and busy without a clock edge
    chk16("pre_abort_ctl", control, 16'h0001);
    tick();
    chk16("abort_inc_ctl", control, 16'h0002);
    #2;
    reset_n = 1'b0;
    #1;
    chk16("abort_ctl", control, 16'h0000);
    chk1("abort_busy", busy, 1'b0);
    tick();
    tick();
    start       = 1'b0;
    single_step = 1'b1;
    instr       = 8'h00;
    reset_n     = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk16("post_rst_idle_ctl", control, 16'h0000);
      chk1("post_rst_idle_busy", busy, 1'b0);
      chk16("post_rst_imm", {12'h000, imm}, 16'h0000);
    end

    // AUTO_RUN leaves IDLE on the first clock, only once
    chk16("auto_rst_ctl", control_a, 16'h0000);
    reset_auto_n = 1'b1;
    tick();
    chk16("auto_fetch_ctl", control_a, 16'h0001);
    chk1("auto_fetch_busy", busy_a, 1'b1);
    tick();
    chk16("auto_inc_ctl", control_a, 16'h0002);
    chk16("auto_imm", {12'h000, imm_a}, 16'h0000);
    tick();
    chk16("auto_exec_ctl", control_a, 16'h0000);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk16("auto_idle_ctl", control_a, 16'h0000);
      chk1("auto_idle_busy", busy_a, 1'b0);
      chk1("auto_idle_halted", halted_a, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/control_sequencer.md
Name: control_sequencer

Overview:
- Fetch/decode/execute FSM for the 4-bit microcontroller; it is the driver of the 16-bit one-hot control bus that all datapath registers, the PC and the ALU load from.
- Latches each 8-bit instruction word from program memory into an internal IR.
- Issues exactly one control bit per cycle, or none.
- Exposes the 4-bit immediate field to the datapath.

Parameters:
- INSTR_W, 8, instruction width; opcode = instr[INSTR_W-1:INSTR_W-4], immediate = instr[DATA_W-1:0].
- DATA_W, 4, immediate/data width.
- AUTO_RUN, 0, 1 = leave IDLE on the first clock after reset without waiting for start.

Ports:
- clk  input  1  system clock, rising edge.
- reset_n  input  1  one clock; reset is asynchronous and active-low.
- start  input  1  level; leaves IDLE/HALT when high.
- single_step  input  1  1 = return to IDLE after each instruction.
- instr  input  INSTR_W  program memory word addressed by the external PC.
- zero_flag  input  1  ALU zero flag (registered externally).
- carry_flag  input  1  ALU carry flag (registered externally).
- control  output  16  one-hot control word (all-zero = no-op), registered.
- imm  output  DATA_W  IR immediate field, registered.
- busy  output  1  high in FETCH/INC/EXEC.
- halted  output  1  high in HALT.

Behaviour:
- Reset (async, reset_n=0):
  - state=IDLE; IR, control, imm, busy and halted all 0.
  - Reset asserted mid-instruction aborts it; control is 0 immediately (asynchronous clear).
- Control bit map:
  - 0 IR_LD, 1 PC_INC, 2 PC_LD, 3 A_LD (A<=imm), 4 B_LD (B<=imm).
  - 5 ADD, 6 SUB, 7 AND, 8 OR, 9 XOR (each means A<=A op B and flags update).
  - 10 OUT_LD, 11 FLAG_CLR, 12-14 reserved (always 0), 15 HALT_IND.
- control is registered from next-state logic and is valid during the cycle the FSM occupies that state. $onehot0(control) must hold every cycle.
- States and transitions:
  - IDLE: control=0. Next FETCH if start=1 or AUTO_RUN=1 (AUTO_RUN applies only on the first exit after reset).
  - FETCH: control=IR_LD. IR<=instr at the end of the cycle; imm updates the same edge. Next INC.
  - INC: control=PC_INC. Next EXEC.
  - EXEC: control is decoded from IR[7:4]:
    - 0 NOP -> 0.
    - 1 LDA -> A_LD; 2 LDB -> B_LD.
    - 3 ADD, 4 SUB, 5 AND, 6 OR, 7 XOR -> matching ALU bit.
    - 8 OUT -> OUT_LD.
    - 9 JMP -> PC_LD.
    - A JZ -> PC_LD if zero_flag else 0.
    - B JC -> PC_LD if carry_flag else 0.
    - C CLF -> FLAG_CLR.
    - D, E reserved -> 0 (treated as NOP).
    - F HLT -> 0 and go to HALT.
  - EXEC next state: HALT if opcode F; else IDLE if single_step=1; else FETCH.
  - HALT: control=HALT_IND held; halted=1. Next FETCH on start=1 (resumes at the already-incremented PC).
- Flags are sampled combinationally in the cycle before EXEC, so the registered control reflects flag values at the end of INC.
- Latency: 3 cycles per instruction (FETCH, INC, EXEC) when free-running. Branch target = imm, applied by the external PC on PC_LD.
- start held high in IDLE/HALT: one transition only. Re-arming is not required; start is level-sensitive.
- Simultaneous start and single_step in IDLE: start wins and executes one instruction, then returns to IDLE.
- busy=1 in FETCH/INC/EXEC, else 0. busy and halted are never both 1.

Test Plan:
- Reset then start=1 with instr=8'h15 -> control sequence 0x0001, 0x0002, 0x0008 on consecutive cycles; imm=4'h5 from the FETCH edge onward.
- Free run through 8'h13, 8'h22, 8'h30 -> EXEC controls 0x0008, 0x0010, 0x0020; next FETCH follows each EXEC with no idle cycle.
- JZ 8'hA7: with zero_flag=1 -> EXEC control 0x0004 and imm=7. Repeat with zero_flag=0 -> EXEC control 0x0000.
- HLT 8'hF0 -> control 0x8000 held, halted=1, busy=0 for 10+ cycles. Pulse start -> FETCH with control 0x0001, halted=0.
- single_step=1 with instr=8'h80 -> one FETCH/INC/EXEC (EXEC control 0x0400), then IDLE with control 0; no further activity until start.
- Drop reset_n mid-INC -> control=0, busy=0 asynchronously. After release, stays IDLE (AUTO_RUN=0); with AUTO_RUN=1 enters FETCH on the first clock.
